ppu_cpu_regs: RTL and testbench

CPU-facing register responder for the PPU: decodes the eight memory-mapped registers ($2000–$2007) driven by the CPU bus, and keeps PPUCTRL/PPUMASK/status, the shared write toggle, the VRAM address with auto-increment, the PPUDATA read buffer, OAM address/data access and scroll values. It sits between the CPU bus and the PPU's VRAM/OAM ports and renderer, and drives NMI_n. It is the responding end of the CPU_ADDR/CPU_DATA_IN/CPU_wren/CPU_rden protocol.

---
 rtl/ppu_cpu_regs_if.sv | 25 ++
 rtl/ppu_cpu_regs.sv | 194 +++++++++++++++++++
 tb/tb_ppu_cpu_regs.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_cpu_regs_if.sv
// CPU-side register bus of the PPU: 3-bit register select, write data,
// level access strobes and the read-data return path.
interface ppu_cpu_regs_if;
    logic [2:0] CPU_ADDR;
    logic [7:0] CPU_DATA_IN;
    logic       CPU_wren;
    logic       CPU_rden;
    logic [7:0] CPU_DATA_OUT;

    modport master (
        output CPU_ADDR,
        output CPU_DATA_IN,
        output CPU_wren,
        output CPU_rden,
        input  CPU_DATA_OUT
    );

    modport slave (
        input  CPU_ADDR,
        input  CPU_DATA_IN,
        input  CPU_wren,
        input  CPU_rden,
        output CPU_DATA_OUT
    );
endinterface

// File: rtl/ppu_cpu_regs.sv
// PPU register file at $2000-$2007: control/mask/status, shared write toggle,
// VRAM address with auto-increment, buffered PPUDATA reads, OAM and scroll.
module ppu_cpu_regs (
    input  logic          CLK,
    input  logic          RESET_n,
    ppu_cpu_regs_if.slave cpu,
    output logic          NMI_n,
    output logic [13:0]   VRAM_ADDR,
    output logic [7:0]    VRAM_DATA_OUT,
    input  logic [7:0]    VRAM_DATA_IN,
    output logic          VRAM_wren,
    output logic          VRAM_rden,
    output logic [7:0]    OAM_ADDR,
    output logic [7:0]    OAM_DATA_OUT,
    output logic          OAM_wren,
    input  logic [7:0]    OAM_DATA_IN,
    input  logic          VBLANK_SET,
    input  logic          VBLANK_CLR,
    input  logic          SPR0_HIT,
    input  logic          SPR_OVF,
    output logic [7:0]    PPUCTRL,
    output logic [7:0]    PPUMASK,
    output logic [7:0]    SCROLL_X,
    output logic [7:0]    SCROLL_Y
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t      state, state_nxt;
    logic        wren_q, rden_q;
    logic        wr_edge, rd_edge;
    logic        pend, pend_wr;
    logic [2:0]  pend_addr;
    logic [7:0]  pend_data;
    logic        park;
    logic        acc_wr, acc_rd;
    logic [2:0]  acc_addr;
    logic [7:0]  acc_data;
    logic [13:0] v, v_inc;
    logic        w;
    logic        palette;
    logic [7:0]  rd_buf;
    logic [7:0]  io_latch;
    logic        vblank;
    logic        status_rd;

    assign VRAM_ADDR = v;

    // An edge that cannot be serviced now (busy, or an older one still queued) is parked.
    always_comb begin
        wr_edge  = cpu.CPU_wren & ~wren_q;
        rd_edge  = cpu.CPU_rden & ~rden_q & ~wr_edge;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        acc_addr = cpu.CPU_ADDR;
        acc_data = cpu.CPU_DATA_IN;
        if (state == IDLE) begin
            if (pend) begin
                acc_wr   = pend_wr;
                acc_rd   = ~pend_wr;
                acc_addr = pend_addr;
                acc_data = pend_data;
            end else begin
                acc_wr = wr_edge;
                acc_rd = rd_edge;
            end
        end
        park      = (wr_edge | rd_edge) & ((state != IDLE) | pend);
        v_inc     = v + (PPUCTRL[2] ? 14'd32 : 14'd1);
        palette   = (v >= 14'h3F00);
        status_rd = acc_rd & (acc_addr == 3'd2);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc_rd && acc_addr == 3'd7)
                    state_nxt = RD_WAIT;
                else if (acc_wr && (acc_addr == 3'd7 || acc_addr == 3'd4))
                    state_nxt = WR_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wren_q           <= 1'b0;
            rden_q           <= 1'b0;
            pend             <= 1'b0;
            pend_wr          <= 1'b0;
            pend_addr        <= '0;
            pend_data        <= '0;
            v                <= '0;
            w                <= 1'b0;
            rd_buf           <= '0;
            io_latch         <= '0;
            vblank           <= 1'b0;
            NMI_n            <= 1'b1;
            VRAM_DATA_OUT    <= '0;
            VRAM_wren        <= 1'b0;
            VRAM_rden        <= 1'b0;
            OAM_ADDR         <= '0;
            OAM_DATA_OUT     <= '0;
            OAM_wren         <= 1'b0;
            PPUCTRL          <= '0;
            PPUMASK          <= '0;
            SCROLL_X         <= '0;
            SCROLL_Y         <= '0;
            cpu.CPU_DATA_OUT <= '0;
        end else begin
            wren_q    <= cpu.CPU_wren;
            rden_q    <= cpu.CPU_rden;
            VRAM_wren <= 1'b0;
            VRAM_rden <= 1'b0;
            OAM_wren  <= 1'b0;
            NMI_n     <= ~(PPUCTRL[7] & vblank);

            if (park) begin
                pend      <= 1'b1;
                pend_wr   <= wr_edge;
                pend_addr <= cpu.CPU_ADDR;
                pend_data <= cpu.CPU_DATA_IN;
            end else if (state == IDLE) begin
                pend <= 1'b0;
            end

            // A status read also clears the flag, which covers set/read suppression.
            if (VBLANK_CLR || status_rd) vblank <= 1'b0;
            else if (VBLANK_SET)         vblank <= 1'b1;

            case (state)
                RD_WAIT: begin
                    rd_buf <= VRAM_DATA_IN;
                    v      <= v_inc;
                    if (palette) cpu.CPU_DATA_OUT <= VRAM_DATA_IN;
                end
                WR_WAIT: begin
                    if (VRAM_wren) v <= v_inc;
                    if (OAM_wren)  OAM_ADDR <= OAM_ADDR + 8'd1;
                end
                default: ;
            endcase

            if (acc_wr) begin
                io_latch <= acc_data;
                case (acc_addr)
                    3'd0: PPUCTRL <= acc_data;
                    3'd1: PPUMASK <= acc_data;
                    3'd3: OAM_ADDR <= acc_data;
                    3'd4: begin
                        OAM_DATA_OUT <= acc_data;
                        OAM_wren     <= 1'b1;
                    end
                    3'd5: begin
                        if (!w) SCROLL_X <= acc_data;
                        else    SCROLL_Y <= acc_data;
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) v[13:8] <= acc_data[5:0];
                        else    v[7:0]  <= acc_data;
                        w <= ~w;
                    end
                    3'd7: begin
                        VRAM_DATA_OUT <= acc_data;
                        VRAM_wren     <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (acc_rd) begin
                case (acc_addr)
                    3'd2: begin
                        cpu.CPU_DATA_OUT <= {vblank & ~VBLANK_SET, SPR0_HIT, SPR_OVF, io_latch[4:0]};
                        w                <= 1'b0;
                    end
                    3'd4: cpu.CPU_DATA_OUT <= OAM_DATA_IN;
                    3'd7: begin
                        VRAM_rden <= 1'b1;
                        if (!palette) cpu.CPU_DATA_OUT <= rd_buf;
                    end
                    default: cpu.CPU_DATA_OUT <= io_latch;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Bench for ppu_cpu_regs: random accesses against a register-level model,
// a constant vector table, and directed multi-cycle corner sequences.
module tb_ppu_cpu_regs;
    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        NMI_n;
    logic [13:0] VRAM_ADDR;
    logic [7:0]  VRAM_DATA_OUT, VRAM_DATA_IN;
    logic        VRAM_wren, VRAM_rden;
    logic [7:0]  OAM_ADDR, OAM_DATA_OUT, OAM_DATA_IN;
    logic        OAM_wren;
    logic        VBLANK_SET, VBLANK_CLR, SPR0_HIT, SPR_OVF;
    logic [7:0]  PPUCTRL, PPUMASK, SCROLL_X, SCROLL_Y;

    ppu_cpu_regs_if bus ();

    ppu_cpu_regs dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .cpu          (bus),
        .NMI_n        (NMI_n),
        .VRAM_ADDR    (VRAM_ADDR),
        .VRAM_DATA_OUT(VRAM_DATA_OUT),
        .VRAM_DATA_IN (VRAM_DATA_IN),
        .VRAM_wren    (VRAM_wren),
        .VRAM_rden    (VRAM_rden),
        .OAM_ADDR     (OAM_ADDR),
        .OAM_DATA_OUT (OAM_DATA_OUT),
        .OAM_wren     (OAM_wren),
        .OAM_DATA_IN  (OAM_DATA_IN),
        .VBLANK_SET   (VBLANK_SET),
        .VBLANK_CLR   (VBLANK_CLR),
        .SPR0_HIT     (SPR0_HIT),
        .SPR_OVF      (SPR_OVF),
        .PPUCTRL      (PPUCTRL),
        .PPUMASK      (PPUMASK),
        .SCROLL_X     (SCROLL_X),
        .SCROLL_Y     (SCROLL_Y)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 13) ^ (a >> 6));
    endfunction

    // VRAM/OAM environment: combinational read, write on the strobe edge
    logic [7:0]  env_mem [0:16383];
    logic [7:0]  oam_mem [0:255];
    logic [13:0] log_a[$];
    logic [7:0]  log_d[$];
    int          rd_pulses = 0;
    bit          mem_ready = 1'b0;

    assign VRAM_DATA_IN = VRAM_rden ? env_mem[VRAM_ADDR] : 8'h00;
    assign OAM_DATA_IN  = oam_mem[OAM_ADDR];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16384; i++) env_mem[i] = pat(i);
            for (int i = 0; i < 256; i++)   oam_mem[i] = pat(i + 99);
            mem_ready = 1'b1;
        end
        if (VRAM_wren) begin
            env_mem[VRAM_ADDR] = VRAM_DATA_OUT;
            log_a.push_back(VRAM_ADDR);
            log_d.push_back(VRAM_DATA_OUT);
        end
        if (VRAM_rden) rd_pulses++;
        if (OAM_wren) oam_mem[OAM_ADDR] = OAM_DATA_OUT;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Register-level reference model
    int         m_v, m_oam;
    bit         m_w, m_vb;
    logic [7:0] m_ctrl, m_mask, m_sx, m_sy, m_latch, m_buf;
    logic [7:0] ref_mem [0:16383];
    logic [7:0] ref_oam [0:255];
    int         exp_a[$];
    logic [7:0] exp_d[$];

    task automatic m_reset();
        m_v = 0; m_oam = 0; m_w = 0; m_vb = 0;
        m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_latch = 0; m_buf = 0;
    endtask

    function automatic int m_step();
        return m_ctrl[2] ? 32 : 1;
    endfunction

    task automatic m_write(input int a, input logic [7:0] d);
        m_latch = d;
        case (a)
            0: m_ctrl = d;
            1: m_mask = d;
            3: m_oam = d;
            4: begin ref_oam[m_oam] = d; m_oam = (m_oam + 1) % 256; end
            5: begin if (!m_w) m_sx = d; else m_sy = d; m_w = !m_w; end
            6: begin
                if (!m_w) m_v = (int'(d) % 64) * 256 + (m_v % 256);
                else      m_v = (m_v / 256) * 256 + int'(d);
                m_w = !m_w;
            end
            7: begin
                ref_mem[m_v] = d;
                exp_a.push_back(m_v);
                exp_d.push_back(d);
                m_v = (m_v + m_step()) % 16384;
            end
            default: ;
        endcase
    endtask

    task automatic m_read(input int a, output logic [7:0] r);
        case (a)
            2: begin r = {m_vb, SPR0_HIT, SPR_OVF, m_latch[4:0]}; m_vb = 0; m_w = 0; end
            4: r = ref_oam[m_oam];
            7: begin
                r = (m_v >= 'h3F00) ? ref_mem[m_v] : m_buf;
                m_buf = ref_mem[m_v];
                m_v = (m_v + m_step()) % 16384;
            end
            default: r = m_latch;
        endcase
    endtask

    task automatic access(input bit wr, input logic [2:0] a, input logic [7:0] d, input int hold);
        @(negedge CLK);
        bus.CPU_ADDR    = a;
        bus.CPU_DATA_IN = d;
        if (wr) bus.CPU_wren = 1'b1;
        else    bus.CPU_rden = 1'b1;
        repeat (hold) @(negedge CLK);
        bus.CPU_wren = 1'b0;
        bus.CPU_rden = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_n = 1'b0;
        bus.CPU_wren = 1'b0; bus.CPU_rden = 1'b0;
        VBLANK_SET = 1'b0; VBLANK_CLR = 1'b0; SPR0_HIT = 1'b0; SPR_OVF = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        m_reset();
    endtask

    typedef enum {C_V, C_OUT, C_CTRL, C_OAM, C_SX, C_SY} chk_t;
    typedef struct {
        bit          wr;
        logic [2:0]  a;
        logic [7:0]  d;
        int          hold;
        chk_t        k;
        logic [13:0] e;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input bit wr, input logic [2:0] a, input logic [7:0] d,
                                input int hold, input chk_t k, input logic [13:0] e);
        vec_t t;
        t.wr = wr; t.a = a; t.d = d; t.hold = hold; t.k = k; t.e = e;
        return t;
    endfunction

    initial begin
        int         ra, rh, base, base_rd;
        bit         rw;
        logic [7:0] rd, r;
        logic [15:0] act;

        RESET_n = 1'b0;
        bus.CPU_ADDR = '0; bus.CPU_DATA_IN = '0; bus.CPU_wren = 1'b0; bus.CPU_rden = 1'b0;
        VBLANK_SET = 1'b0; VBLANK_CLR = 1'b0; SPR0_HIT = 1'b0; SPR_OVF = 1'b0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = pat(i);
        for (int i = 0; i < 256; i++)   ref_oam[i] = pat(i + 99);

        // Reset values
        do_reset();
        chk("rst_nmi", 16'(NMI_n), 16'h1);
        chk("rst_vaddr", 16'(VRAM_ADDR), 16'h0);
        chk("rst_ctrl", 16'(PPUCTRL), 16'h0);
        chk("rst_mask", 16'(PPUMASK), 16'h0);
        chk("rst_sx", 16'(SCROLL_X), 16'h0);
        chk("rst_sy", 16'(SCROLL_Y), 16'h0);
        chk("rst_oam", 16'(OAM_ADDR), 16'h0);
        chk("rst_out", 16'(bus.CPU_DATA_OUT), 16'h0);
        chk("rst_strobes", 16'({VRAM_wren, VRAM_rden, OAM_wren}), 16'h0);

        // Random accesses against the model
        base = log_a.size();
        for (int n = 0; n < 300; n++) begin
            ra = int'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            rh = int'($urandom_range(1, 3));
            SPR0_HIT = 1'($urandom_range(0, 1));
            SPR_OVF  = 1'($urandom_range(0, 1));
            access(rw, 3'(ra), rd, rh);
            if (rw) m_write(ra, rd);
            else begin
                m_read(ra, r);
                chk($sformatf("rnd_rd%0d_a%0d", n, ra), 16'(bus.CPU_DATA_OUT), 16'(r));
            end
            chk("rnd_v", 16'(VRAM_ADDR), 16'(m_v));
            chk("rnd_ctrl", 16'(PPUCTRL), 16'(m_ctrl));
            chk("rnd_mask", 16'(PPUMASK), 16'(m_mask));
            chk("rnd_scroll", {SCROLL_X, SCROLL_Y}, {m_sx, m_sy});
            chk("rnd_oam", 16'(OAM_ADDR), 16'(m_oam));
            chk("rnd_nmi", 16'(NMI_n), 16'(!(m_ctrl[7] && m_vb)));
        end
        chk("rnd_wr_count", 16'(log_a.size() - base), 16'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && base + i < log_a.size(); i++) begin
            chk("rnd_wr_addr", 16'(log_a[base + i]), 16'(exp_a[i]));
            chk("rnd_wr_data", 16'(log_d[base + i]), 16'(exp_d[i]));
        end

        // Constant vector table
        tbl.push_back(mk(1, 6, 8'h21, 3, C_V,    14'h2100));
        tbl.push_back(mk(1, 6, 8'h08, 3, C_V,    14'h2108));
        tbl.push_back(mk(1, 0, 8'h04, 1, C_CTRL, 14'h0004));
        tbl.push_back(mk(1, 7, 8'h11, 2, C_V,    14'h2128));
        tbl.push_back(mk(1, 7, 8'h22, 1, C_V,    14'h2148));
        tbl.push_back(mk(1, 0, 8'h00, 1, C_CTRL, 14'h0000));
        tbl.push_back(mk(1, 6, 8'h3F, 1, C_V,    14'h3F48));
        tbl.push_back(mk(1, 6, 8'hFF, 1, C_V,    14'h3FFF));
        tbl.push_back(mk(1, 7, 8'h33, 1, C_V,    14'h0000));
        tbl.push_back(mk(1, 6, 8'h20, 1, C_V,    14'h2000));
        tbl.push_back(mk(1, 6, 8'h00, 1, C_V,    14'h2000));
        tbl.push_back(mk(1, 7, 8'hAA, 1, C_V,    14'h2001));
        tbl.push_back(mk(1, 7, 8'hBB, 1, C_V,    14'h2002));
        tbl.push_back(mk(1, 6, 8'h20, 1, C_V,    14'h2002));
        tbl.push_back(mk(1, 6, 8'h00, 1, C_V,    14'h2000));
        tbl.push_back(mk(0, 7, 8'h00, 1, C_OUT,  14'h0000));
        tbl.push_back(mk(0, 7, 8'h00, 2, C_OUT,  14'h00AA));
        tbl.push_back(mk(0, 7, 8'h00, 1, C_OUT,  14'h00BB));
        tbl.push_back(mk(1, 6, 8'h3F, 1, C_V,    14'h3F03));
        tbl.push_back(mk(1, 6, 8'h00, 1, C_V,    14'h3F00));
        tbl.push_back(mk(1, 7, 8'h0F, 1, C_V,    14'h3F01));
        tbl.push_back(mk(1, 6, 8'h3F, 1, C_V,    14'h3F01));
        tbl.push_back(mk(1, 6, 8'h00, 1, C_V,    14'h3F00));
        tbl.push_back(mk(0, 7, 8'h00, 1, C_OUT,  14'h000F));
        tbl.push_back(mk(1, 6, 8'h3F, 1, C_V,    14'h3F01));
        tbl.push_back(mk(1, 3, 8'hFF, 1, C_OAM,  14'h00FF));
        tbl.push_back(mk(1, 4, 8'h5A, 1, C_OAM,  14'h0000));
        tbl.push_back(mk(1, 3, 8'hFF, 1, C_OAM,  14'h00FF));
        tbl.push_back(mk(0, 4, 8'h00, 1, C_OUT,  14'h005A));
        tbl.push_back(mk(0, 0, 8'h00, 1, C_OUT,  14'h00FF));
        tbl.push_back(mk(0, 2, 8'h00, 1, C_OUT,  14'h001F));
        tbl.push_back(mk(1, 5, 8'h12, 1, C_SX,   14'h0012));
        tbl.push_back(mk(1, 5, 8'h34, 1, C_SY,   14'h0034));

        do_reset();
        base = log_a.size();
        for (int i = 0; i < tbl.size(); i++) begin
            access(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].hold);
            case (tbl[i].k)
                C_V:     act = 16'(VRAM_ADDR);
                C_OUT:   act = 16'(bus.CPU_DATA_OUT);
                C_CTRL:  act = 16'(PPUCTRL);
                C_OAM:   act = 16'(OAM_ADDR);
                C_SX:    act = 16'(SCROLL_X);
                default: act = 16'(SCROLL_Y);
            endcase
            chk($sformatf("tbl%0d", i), act, 16'(tbl[i].e));
        end
        chk("tbl_wr_count", 16'(log_a.size() - base), 16'd6);
        if (log_a.size() - base == 6) begin
            chk("tbl_wr0", {2'b0, log_a[base + 0]}, 16'h2108); chk("tbl_wd0", 16'(log_d[base + 0]), 16'h11);
            chk("tbl_wr1", {2'b0, log_a[base + 1]}, 16'h2128); chk("tbl_wd1", 16'(log_d[base + 1]), 16'h22);
            chk("tbl_wr2", {2'b0, log_a[base + 2]}, 16'h3FFF); chk("tbl_wd2", 16'(log_d[base + 2]), 16'h33);
            chk("tbl_wr3", {2'b0, log_a[base + 3]}, 16'h2000); chk("tbl_wr4", {2'b0, log_a[base + 4]}, 16'h2001);
            chk("tbl_wr5", {2'b0, log_a[base + 5]}, 16'h3F00); chk("tbl_wd5", 16'(log_d[base + 5]), 16'h0F);
        end

        // Status read and NMI timing
        do_reset();
        access(1, 5, 8'h11, 1);
        access(1, 0, 8'h80, 1);
        @(negedge CLK); VBLANK_SET = 1'b1;
        @(negedge CLK); VBLANK_SET = 1'b0;
        chk("nmi_lag", 16'(NMI_n), 16'h1);
        @(negedge CLK);
        chk("nmi_set", 16'(NMI_n), 16'h0);
        access(0, 2, 8'h00, 1);
        chk("stat_vb", 16'(bus.CPU_DATA_OUT), 16'h80);
        chk("nmi_clr", 16'(NMI_n), 16'h1);
        access(1, 5, 8'h55, 1);
        chk("w_clr_x", 16'(SCROLL_X), 16'h55);
        chk("w_clr_y", 16'(SCROLL_Y), 16'h00);

        // Status read edge coinciding with VBLANK_SET
        do_reset();
        access(1, 0, 8'h9F, 1);
        @(negedge CLK); bus.CPU_ADDR = 3'd2; bus.CPU_rden = 1'b1; VBLANK_SET = 1'b1;
        @(negedge CLK); bus.CPU_rden = 1'b0; VBLANK_SET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("sup_read", 16'(bus.CPU_DATA_OUT), 16'h1F);
        chk("sup_nmi", 16'(NMI_n), 16'h1);
        access(0, 2, 8'h00, 1);
        chk("sup_flag", 16'(bus.CPU_DATA_OUT), 16'h1F);

        // VBLANK_SET together with VBLANK_CLR
        do_reset();
        access(1, 0, 8'h80, 1);
        @(negedge CLK); VBLANK_SET = 1'b1; VBLANK_CLR = 1'b1;
        @(negedge CLK); VBLANK_SET = 1'b0; VBLANK_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        chk("setclr_nmi", 16'(NMI_n), 16'h1);
        access(0, 2, 8'h00, 1);
        chk("setclr_flag", 16'(bus.CPU_DATA_OUT), 16'h00);

        // Simultaneous write and read edges on $2007
        do_reset();
        base = log_a.size(); base_rd = rd_pulses;
        @(negedge CLK); bus.CPU_ADDR = 3'd7; bus.CPU_DATA_IN = 8'h5C;
        bus.CPU_wren = 1'b1; bus.CPU_rden = 1'b1;
        @(negedge CLK); bus.CPU_wren = 1'b0; bus.CPU_rden = 1'b0;
        repeat (3) @(negedge CLK);
        chk("both_wr_cnt", 16'(log_a.size() - base), 16'd1);
        chk("both_rd_cnt", 16'(rd_pulses - base_rd), 16'd0);
        chk("both_v", 16'(VRAM_ADDR), 16'h0001);
        if (log_a.size() > base) chk("both_wdata", 16'(log_d[base]), 16'h5C);

        // Write edge arriving during RD_WAIT is serviced afterwards
        do_reset();
        base_rd = rd_pulses;
        @(negedge CLK); bus.CPU_ADDR = 3'd7; bus.CPU_rden = 1'b1;
        @(negedge CLK); bus.CPU_rden = 1'b0; bus.CPU_ADDR = 3'd0; bus.CPU_DATA_IN = 8'h04; bus.CPU_wren = 1'b1;
        @(negedge CLK); bus.CPU_wren = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pend_ctrl", 16'(PPUCTRL), 16'h04);
        chk("pend_v", 16'(VRAM_ADDR), 16'h0001);
        chk("pend_rd_cnt", 16'(rd_pulses - base_rd), 16'd1);

        // Reset in the middle of a $2007 write
        do_reset();
        base = log_a.size();
        @(negedge CLK); bus.CPU_ADDR = 3'd7; bus.CPU_DATA_IN = 8'h77; bus.CPU_wren = 1'b1;
        @(negedge CLK);
        chk("abort_pulse", 16'(VRAM_wren), 16'h1);
        RESET_n = 1'b0; bus.CPU_wren = 1'b0;
        #1;
        chk("abort_wren", 16'(VRAM_wren), 16'h0);
        @(negedge CLK); RESET_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("abort_v", 16'(VRAM_ADDR), 16'h0000);
        chk("abort_log", 16'(log_a.size() - base), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
